// File: rtl/systolic_array.sv
// systolic_array: output-stationary ROWS x COLS signed multiply-accumulate mesh.
//
// Each PE(i,j) owns the accumulator for C[i][j]. The caller drives unskewed
// beats (one k-step per cycle): column k of A on a_in_bus and row k of B on
// b_in_bus. Row i of A is delayed by i registers and column j of B by j
// registers inside the block. Operands and valid then hop one register per PE,
// so beat k reaches PE(i,j) i+j cycles after PE(0,0) samples it.
//
// Ports:
//   clk       input   rising-edge clock
//   rst_n     input   asynchronous active-low reset
//   valid_in  input   marks a beat on a_in_bus / b_in_bus
//   a_in_bus  input   ROWS*DATA_W, A[i][k] at [i*DATA_W +: DATA_W]
//   b_in_bus  input   COLS*DATA_W, B[k][j] at [j*DATA_W +: DATA_W]
//   c_bus     output  ROWS*COLS*ACC_W, C[i][j] at [(i*COLS+j)*ACC_W +: ACC_W]
//   c_valid   output  ROWS*COLS, bit i*COLS+j set once C[i][j] is final
//
// Build option: define SYSTOLIC_ARRAY_SAT_EN to saturate each accumulate to the
// signed ACC_W range; otherwise accumulation wraps modulo 2^ACC_W.

module systolic_array #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int ROWS   = 2,
  parameter int COLS   = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        valid_in,
  input  logic [ROWS*DATA_W-1:0]      a_in_bus,
  input  logic [COLS*DATA_W-1:0]      b_in_bus,
  output logic [ROWS*COLS*ACC_W-1:0]  c_bus,
  output logic [ROWS*COLS-1:0]        c_valid
);

  // Operand/valid arriving at each PE, flattened by PE index i*COLS+j.
  // Column 0 / row 0 entries come from the skew chains, the rest from the
  // neighbouring PE's hop register.
  logic [ROWS*COLS*DATA_W-1:0] w_a_pe;
  logic [ROWS*COLS*DATA_W-1:0] w_b_pe;
  logic [ROWS*COLS-1:0]        w_v_pe;

  // Row skew: A operand and valid travel together so PE(i,0) sees beat k at i.
  for (genvar i = 0; i < ROWS; i++) begin : g_row_skew
    if (i == 0) begin : g_direct
      // PE(0,0) works straight off the bus in the sampling cycle.
      assign w_a_pe[0 +: DATA_W] = a_in_bus[0 +: DATA_W];
      assign w_v_pe[0]           = valid_in;
    end else begin : g_delay
      logic [DATA_W-1:0] r_sa [i];
      logic              r_sv [i];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < i; d++) begin
            r_sa[d] <= '0;
            r_sv[d] <= 1'b0;
          end
        end else begin
          r_sa[0] <= a_in_bus[i*DATA_W +: DATA_W];
          r_sv[0] <= valid_in;
          for (int d = 1; d < i; d++) begin
            r_sa[d] <= r_sa[d-1];
            r_sv[d] <= r_sv[d-1];
          end
        end
      end
      assign w_a_pe[(i*COLS)*DATA_W +: DATA_W] = r_sa[i-1];
      assign w_v_pe[i*COLS]                    = r_sv[i-1];
    end
  end

  // Column skew: valid is carried along the rows, so only B needs delaying.
  for (genvar j = 0; j < COLS; j++) begin : g_col_skew
    if (j == 0) begin : g_direct
      assign w_b_pe[0 +: DATA_W] = b_in_bus[0 +: DATA_W];
    end else begin : g_delay
      logic [DATA_W-1:0] r_sb [j];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < j; d++) r_sb[d] <= '0;
        end else begin
          r_sb[0] <= b_in_bus[j*DATA_W +: DATA_W];
          for (int d = 1; d < j; d++) r_sb[d] <= r_sb[d-1];
        end
      end
      assign w_b_pe[j*DATA_W +: DATA_W] = r_sb[j-1];
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    for (genvar j = 0; j < COLS; j++) begin : g_col
      localparam int N = i*COLS + j;

      logic signed [DATA_W-1:0]   w_a;
      logic signed [DATA_W-1:0]   w_b;
      logic                       w_v;
      logic signed [2*DATA_W-1:0] w_prod;
      logic signed [ACC_W-1:0]    w_pext;
      logic signed [ACC_W-1:0]    w_accum;
      logic signed [ACC_W-1:0]    r_acc;
      logic                       r_v;     // local valid, one cycle late
      logic                       r_done;

      assign w_a    = w_a_pe[N*DATA_W +: DATA_W];
      assign w_b    = w_b_pe[N*DATA_W +: DATA_W];
      assign w_v    = w_v_pe[N];
      assign w_prod = (2*DATA_W)'(w_a) * (2*DATA_W)'(w_b);
      assign w_pext = ACC_W'(w_prod);

`ifdef SYSTOLIC_ARRAY_SAT_EN
      localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
      localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
      logic signed [ACC_W:0] w_sum;
      assign w_sum   = (ACC_W+1)'(r_acc) + (ACC_W+1)'(w_pext);
      // The two top bits disagree only when the ACC_W result overflowed.
      assign w_accum = (w_sum[ACC_W] != w_sum[ACC_W-1])
                     ? (w_sum[ACC_W] ? ACC_MIN : ACC_MAX)
                     : w_sum[ACC_W-1:0];
`else
      assign w_accum = r_acc + w_pext;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_acc  <= '0;
          r_v    <= 1'b0;
          r_done <= 1'b0;
        end else begin
          r_v <= w_v;
          if (w_v) begin
            // First beat of a burst loads, so no clear cycle is needed.
            r_acc <= r_v ? w_accum : w_pext;
            if (!r_v) r_done <= 1'b0;
          end else if (r_v) begin
            r_done <= 1'b1;
          end
        end
      end

      // r_v doubles as the valid hop register towards the right neighbour.
      if (j < COLS-1) begin : g_hop_right
        logic [DATA_W-1:0] r_a;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) r_a <= '0;
          else        r_a <= w_a;
        end
        assign w_a_pe[(N+1)*DATA_W +: DATA_W] = r_a;
        assign w_v_pe[N+1]                    = r_v;
      end

      if (i < ROWS-1) begin : g_hop_down
        logic [DATA_W-1:0] r_b;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) r_b <= '0;
          else        r_b <= w_b;
        end
        assign w_b_pe[(N+COLS)*DATA_W +: DATA_W] = r_b;
      end

      assign c_bus[N*ACC_W +: ACC_W] = r_acc;
      assign c_valid[N]              = r_done;
    end
  end

endmodule

// File: tb/tb_systolic_array.sv
module tb_systolic_array;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [15:0] a_in_bus;
  logic [15:0] b_in_bus;
  logic [127:0] c_bus;
  logic [3:0]  c_valid;

  // 1x1 instance with a narrow accumulator for the overflow case
  logic        valid2;
  logic [7:0]  a2;
  logic [7:0]  b2;
  logic [15:0] c2;
  logic [0:0]  cv2;

  systolic_array #(.DATA_W(8), .ACC_W(32), .ROWS(2), .COLS(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .a_in_bus(a_in_bus), .b_in_bus(b_in_bus),
    .c_bus(c_bus), .c_valid(c_valid)
  );

  systolic_array #(.DATA_W(8), .ACC_W(16), .ROWS(1), .COLS(1)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid2),
    .a_in_bus(a2), .b_in_bus(b2),
    .c_bus(c2), .c_valid(cv2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vec  = 0;
  int miss = 0;
  int cyc  = 0;
  int last_edge = 0;

  longint exp_q [4][$];
  longint exp2_q [$];
  int     rise_cyc [4];
  int     fall_cyc [4];
  logic [3:0] cv_prev = '0;
  logic       cv2_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each rising c_valid bit pops that cell's next result.
  always @(posedge clk) begin
    #1;
    for (int n = 0; n < 4; n++) begin
      if (c_valid[n] && !cv_prev[n]) begin
        rise_cyc[n] = cyc;
        if (exp_q[n].size() == 0) begin
          vec++; miss++;
          $display("FAIL unexpected_c%0d: got %0d, expected no result", n,
                   $signed(c_bus[n*32 +: 32]));
        end else begin
          chk($sformatf("c%0d", n), longint'($signed(c_bus[n*32 +: 32])),
              exp_q[n].pop_front());
        end
      end
      if (!c_valid[n] && cv_prev[n]) fall_cyc[n] = cyc;
    end
    cv_prev = c_valid;
    if (cv2[0] && !cv2_prev) begin
      if (exp2_q.size() == 0) begin
        vec++; miss++;
        $display("FAIL unexpected_c16: got %0d, expected no result", $signed(c2));
      end else begin
        chk("c16_overflow", longint'($signed(c2)), exp2_q.pop_front());
      end
    end
    cv2_prev = cv2[0];
  end

  task automatic push4(input longint c0, input longint c1, input longint c2v,
                       input longint c3);
    exp_q[0].push_back(c0);
    exp_q[1].push_back(c1);
    exp_q[2].push_back(c2v);
    exp_q[3].push_back(c3);
  endtask

  // a0/a1: A column k (rows 0,1); b0/b1: B row k (cols 0,1)
  task automatic beat(input int a0, input int a1, input int b0, input int b1);
    @(negedge clk);
    valid_in = 1'b1;
    a_in_bus = {8'(a1), 8'(a0)};
    b_in_bus = {8'(b1), 8'(b0)};
    last_edge = cyc + 1;
  endtask

  // Idle cycles carry junk on the buses, which must not be accumulated.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
      a_in_bus = 16'($urandom);
      b_in_bus = 16'($urandom);
    end
  endtask

  task automatic beat2(input int a, input int b);
    @(negedge clk);
    valid2 = 1'b1;
    a2 = 8'(a);
    b2 = 8'(b);
  endtask

  int first0;
  int first1;
  int exp_rise [4] = '{2, 3, 3, 4};
  int exp_fall [4] = '{0, 1, 1, 2};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int n = 0; n < 4; n++) begin
      rise_cyc[n] = -100;
      fall_cyc[n] = -100;
    end
    rst_n = 1'b0; valid_in = 1'b0; a_in_bus = '0; b_in_bus = '0;
    valid2 = 1'b0; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_c_bus",   longint'(c_bus == '0), 1);
    chk("reset_c_valid", longint'(c_valid), 0);
    chk("reset_c16",     longint'(c2), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic 2x2 product, K=2, with c_valid rise timing
    push4(19, 22, 43, 50);
    beat(1, 3, 5, 6);
    first0 = last_edge;
    beat(2, 4, 7, 8);
    idle(6);
    for (int n = 0; n < 4; n++)
      chk($sformatf("rise_delay_c%0d", n), longint'(rise_cyc[n] - first0),
          longint'(exp_rise[n]));

    // Signed extremes
    push4(16383, -255, 127, -127);
    beat(-128, 0, -128, 2);
    beat(-1, 127, 1, -1);
    idle(6);

    // Burst restart after a single idle cycle, no carry-over
    push4(19, 22, 43, 50);
    push4(8, 10, 12, 15);
    beat(1, 3, 5, 6);
    beat(2, 4, 7, 8);
    idle(1);
    beat(2, 3, 4, 5);
    first1 = last_edge;
    idle(6);
    for (int n = 0; n < 4; n++)
      chk($sformatf("drop_delay_c%0d", n), longint'(fall_cyc[n] - first1),
          longint'(exp_fall[n]));

    // Longer burst, K=3, mixed signs
    push4(-9, 4, 11, 9);
    beat(1, 3, 1, 2);
    beat(0, 1, 3, 4);
    beat(-2, 1, 5, -1);
    idle(7);

    // Reset mid-burst discards everything
    beat(1, 3, 5, 6);
    @(negedge clk);
    rst_n = 1'b0;
    valid_in = 1'b0;
    #1;
    chk("midreset_c_bus",   longint'(c_bus == '0), 1);
    chk("midreset_c_valid", longint'(c_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    push4(19, 22, 43, 50);
    beat(1, 3, 5, 6);
    beat(2, 4, 7, 8);
    idle(6);

    // Overflow on a 16-bit accumulator: 3 * 127*127 = 48387
`ifdef SYSTOLIC_ARRAY_SAT_EN
    exp2_q.push_back(32767);
`else
    exp2_q.push_back(48387 - 65536);
`endif
    beat2(127, 127);
    beat2(127, 127);
    beat2(127, 127);
    @(negedge clk);
    valid2 = 1'b0;
    repeat (4) @(negedge clk);

    for (int n = 0; n < 4; n++) begin
      if (exp_q[n].size() != 0) begin
        vec++; miss++;
        $display("FAIL pending_c%0d: got %0d results missing, expected 0", n,
                 exp_q[n].size());
      end
    end
    if (exp2_q.size() != 0) begin
      vec++; miss++;
      $display("FAIL pending_c16: got %0d results missing, expected 0", exp2_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
